// File: rtl/sprite_pkg.sv
// Shared constants, palette table and writer state type
// for the sprite RAM write path.
package sprite_pkg;

    localparam int COLOR_W = 12;
    localparam int IDX_W   = 4;
    localparam int PAL_N   = 5;

    // Entry 0 doubles as the transparent colour and the
    // fallback index for colours not found in the table.
    localparam logic [COLOR_W-1:0] PAL [0:PAL_N-1] = '{
        12'h808,
        12'h000,
        12'hFCC,
        12'h940,
        12'h0AE
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wr_state_t;

endpackage

// File: rtl/palette_encoder.sv
// Reverse palette lookup: RGB444 colour -> palette index.
// Ports: i_color (in), o_idx (index, 0 on miss), o_hit (match found).
module palette_encoder
    import sprite_pkg::*;
(
    input  logic [COLOR_W-1:0] i_color,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_hit
);

    // Scan from the top so the lowest matching index is
    // the last one assigned and therefore wins.
    always_comb begin
        o_idx = '0;
        o_hit = 1'b0;
        for (int i = PAL_N - 1; i >= 0; i--) begin
            if (i_color == PAL[i]) begin
                o_idx = IDX_W'(i);
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_ram_writer.sv
// Streams RGB444 pixels into a palette-indexed sprite RAM, one write per pixel.
// Ports: Clk, Reset_n, start, abort, pixel_valid/pixel_color/pixel_ready (pixel
// stream), wr_en/wr_addr/wr_data (RAM write), busy, done, miss_count.
module sprite_ram_writer
    import sprite_pkg::*;
#(
    parameter int DEPTH  = 61952,
    parameter int ADDR_W = 18
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic               pixel_valid,
    input  logic [COLOR_W-1:0] pixel_color,
    output logic               pixel_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [IDX_W-1:0]   wr_data,
    output logic               busy,
    output logic               done,
    output logic [15:0]        miss_count
);

    wr_state_t         r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [15:0]       r_miss;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [IDX_W-1:0]  r_wr_data;

    logic              w_xfer;
    logic              w_last;
    logic [IDX_W-1:0]  w_idx;
    logic              w_hit;

    palette_encoder u_enc (
        .i_color (pixel_color),
        .o_idx   (w_idx),
        .o_hit   (w_hit)
    );

    assign pixel_ready = (r_state == RUN);
    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign w_xfer      = pixel_valid & pixel_ready;
    assign w_last      = (r_cnt == ADDR_W'(DEPTH - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_miss  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                        r_miss  <= '0;
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        if (!w_hit && r_miss != 16'hFFFF)
                            r_miss <= r_miss + 16'd1;
                        // Counter parks on the last address.
                        if (w_last)
                            r_state <= DONE;
                        else
                            r_cnt <= r_cnt + 1'b1;
                    end
                    // A final transfer overrides a same-cycle abort.
                    if (abort && !(w_xfer && w_last))
                        r_state <= IDLE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // One register stage between accepted pixel and RAM write.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_xfer;
            if (w_xfer) begin
                r_wr_addr <= r_cnt;
                r_wr_data <= w_idx;
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign miss_count = r_miss;

endmodule
